tick_gen: RTL and testbench
===========================

# tick_gen

Programmable enable-tick generator that sits directly upstream of the mod-N counter and drives its `en` input. It emits a single-cycle `tick` every `D` clock cycles while running, so the counter advances at a divided rate. Start/stop control, a shadowed divisor reload, and phase resynchronisation are handled by a two-state FSM.

## Interface
- `DIV_W`, 16: width of the divisor and phase counter.
- `DEFAULT_DIV`, 10: divisor loaded at reset; must be in 1..2^DIV_W-1.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level, sampled each edge; IDLE→RUN, or phase resync while in RUN.
- `stop`  in  1  level, sampled each edge; RUN→IDLE.
- `div_load`  in  1  writes `div_in` into the shadow divisor.
- `div_in`  in  DIV_W  new divisor value.
- `oneshot`  in  1  only present with `TICK_GEN_ONESHOT_EN`; sampled together with `start`.
- `tick`  out  1  registered single-cycle pulse; connect to the counter's `en`.
- `running`  out  1  high in RUN.
- `phase`  out  DIV_W  current phase count, 0..D-1.

## Operation
- Reset: `tick`=0, `running`=0, `phase`=0, state IDLE, active and shadow divisor = `DEFAULT_DIV`.
- Divisor:
  - `div_load` writes the shadow register on the next edge, in any state.
  - The active divisor D is copied from the shadow on an accepted `start` and on every edge that produces a tick. A new value therefore never truncates the current period.
  - `div_in`=0 is stored as 1.
  - If `div_load` and the copy happen on the same edge, `div_in` is forwarded directly into D.
- IDLE:
  - `phase` held at 0, `tick`=0.
  - `start`=1 and `stop`=0 → RUN, `phase`←0.
- RUN, on each edge:
  - `stop`=1 → IDLE, `phase`←0, `tick`←0. `stop` has priority over `start` and over a pending tick.
  - else `start`=1 → resync: `phase`←0, `tick`←0, D reloaded from the shadow.
  - else `phase`==D-1 → `phase`←0, `tick`←1.
  - else `phase`←`phase`+1, `tick`←0.
- `phase` arithmetic is DIV_W-bit unsigned. Wrap occurs only at D-1, never at 2^DIV_W.

## Timing
- Edge numbering: edge 0 is the edge that samples `start` in IDLE. `running` is high after edge 0.
- First `tick` is high in the cycle following edge D. Subsequent ticks follow every D cycles.
- Each `tick` lasts exactly 1 cycle. With D=1, `tick` is high continuously from the cycle after edge 1.
- A `stop` sampled at edge k gives `running`=0 and `tick`=0 after edge k. No tick is emitted after a stop edge.
- Asserting `reset_n` mid-operation returns all outputs to their reset values immediately (asynchronously), and the divisor returns to `DEFAULT_DIV`.

## Configuration
- `TICK_GEN_ONESHOT_EN` defined:
  - Adds the `oneshot` port.
  - If `oneshot`=1 when `start` is accepted from IDLE, the block produces exactly one tick (after edge D) and returns to IDLE on that same edge. `running` falls together with `tick` rising.
  - A resync `start` in RUN re-samples `oneshot`.
- Not defined:
  - No `oneshot` port; the block always runs free until `stop`.

## Test plan
- Reset, then `start` pulse with D=10 → `running`=1 after edge 0. Ticks after edges 10, 20, 30, each exactly 1 cycle wide, with `phase` counting 0..9.
- `div_load` with `div_in`=3 at edge 14, while running at D=10 → next tick still after edge 20, then after edges 23, 26.
- `div_in`=0 loaded, then `start` → D=1, `tick` high every cycle from edge 1 onward.
- `start` and `stop` both high at edge 5 while in RUN → IDLE, `running`=0, `phase`=0, and no tick at edge 10.
- Resync `start` at edge 7 with D=10 → `phase`←0, next tick after edge 17. Also assert `reset_n` low mid-period → outputs 0 immediately and D=10.
- With `TICK_GEN_ONESHOT_EN` defined, `start`+`oneshot` with D=4 → exactly one tick after edge 4, `running`=0 after edge 4, and no further ticks over the next 20 cycles.

Source files
------------

// File: rtl/tick_gen.sv
// Programmable enable-tick generator: one-cycle tick every D clocks while running.
// Define TICK_GEN_ONESHOT_EN to add the oneshot port (single tick, then back to IDLE).
module tick_gen #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_in,
`ifdef TICK_GEN_ONESHOT_EN
    input  logic             oneshot,
`endif
    output logic             tick,
    output logic             running,
    output logic [DIV_W-1:0] phase
);

    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] phase_d;
    logic             tick_d;
    logic [DIV_W-1:0] div_act, div_d;
    logic [DIV_W-1:0] div_shadow, shadow_d;
    logic [DIV_W-1:0] div_in_fix;
    logic             os_q, os_d, os_in;

`ifdef TICK_GEN_ONESHOT_EN
    assign os_in = oneshot;
`else
    assign os_in = 1'b0;
`endif

    // A zero divisor would never wrap; treat it as divide-by-one.
    assign div_in_fix = (div_in == '0) ? ONE : div_in;
    // Same-edge load forwards straight into the active divisor on a copy.
    assign shadow_d   = div_load ? div_in_fix : div_shadow;
    assign running    = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            phase      <= '0;
            tick       <= 1'b0;
            div_act    <= DEF_DIV;
            div_shadow <= DEF_DIV;
            os_q       <= 1'b0;
        end else begin
            state      <= state_d;
            phase      <= phase_d;
            tick       <= tick_d;
            div_act    <= div_d;
            div_shadow <= shadow_d;
            os_q       <= os_d;
        end
    end

    always_comb begin
        state_d = state;
        phase_d = phase;
        tick_d  = 1'b0;
        div_d   = div_act;
        os_d    = os_q;
        case (state)
            IDLE: begin
                phase_d = '0;
                if (start && !stop) begin
                    state_d = RUN;
                    div_d   = shadow_d;
                    os_d    = os_in;
                end
            end
            RUN: begin
                // stop beats resync, which beats a pending tick
                if (stop) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else if (start) begin
                    phase_d = '0;
                    div_d   = shadow_d;
                    os_d    = os_in;
                end else if (phase == div_act - ONE) begin
                    phase_d = '0;
                    tick_d  = 1'b1;
                    div_d   = shadow_d;
                    if (os_q) state_d = IDLE;
                end else begin
                    phase_d = phase + ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed scenarios plus randomized run vs. a
// next-tick-time reference model.
module tb_tick_gen;
    localparam int DIV_W = 16;
`ifdef TICK_GEN_ONESHOT_EN
    localparam bit OS_EN = 1'b1;
`else
    localparam bit OS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0, stop = 1'b0, div_load = 1'b0, oneshot = 1'b0;
    logic [DIV_W-1:0] div_in = '0;
    logic             tick, running;
    logic [DIV_W-1:0] phase;

    int n_pass = 0;
    int n_chk  = 0;

    tick_gen #(.DIV_W(DIV_W), .DEFAULT_DIV(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .div_load(div_load), .div_in(div_in),
`ifdef TICK_GEN_ONESHOT_EN
        .oneshot(oneshot),
`endif
        .tick(tick), .running(running), .phase(phase)
    );

    always #5 clk = ~clk;

    // Reference model: absolute edge number n, edge of next tick nxt, divisor d.
    bit m_run, m_tick, m_os;
    int m_d, m_shadow, m_n, m_nxt;

    function automatic int m_phase();
        return m_run ? (m_d - (m_nxt - m_n)) : 0;
    endfunction

    task automatic model_reset();
        m_run = 0; m_tick = 0; m_os = 0; m_d = 10; m_shadow = 10; m_nxt = 0;
    endtask

    task automatic model_edge();
        int fwd;
        m_n++;
        if (div_load) m_shadow = (div_in == 0) ? 1 : int'(div_in);
        fwd    = m_shadow;
        m_tick = 0;
        if (!m_run) begin
            if (start && !stop) begin
                m_run = 1; m_d = fwd; m_nxt = m_n + m_d; m_os = OS_EN && oneshot;
            end
        end else if (stop) begin
            m_run = 0;
        end else if (start) begin
            m_d = fwd; m_nxt = m_n + m_d; m_os = OS_EN && oneshot;
        end else if (m_n == m_nxt) begin
            m_tick = 1; m_d = fwd; m_nxt = m_n + m_d;
            if (m_os) m_run = 0;
        end
    endtask

    task automatic drive_edge(input bit s, input bit p, input bit ld, input int din, input bit os);
        start = s; stop = p; div_load = ld; div_in = DIV_W'(din); oneshot = os;
        @(posedge clk);
        model_edge();
        #1;
        start = 0; stop = 0; div_load = 0; oneshot = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset_n = 0;
        model_reset();
        #1;
        n_chk++; if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick); else n_pass++;
        n_chk++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else n_pass++;
        n_chk++; if (phase !== '0) $display("FAIL reset_phase got %0d want 0", phase); else n_pass++;
        @(posedge clk); #1 reset_n = 1;
    endtask

    task automatic test_basic();
        do_reset();
        drive_edge(1, 0, 0, 0, 0);
        n_chk++; if (running !== 1'b1) $display("FAIL basic_running0 got %b want 1", running); else n_pass++;
        for (int e = 1; e <= 35; e++) begin
            drive_edge(0, 0, 0, 0, 0);
            n_chk++;
            if (tick !== (e % 10 == 0)) $display("FAIL basic_tick e=%0d got %b want %b", e, tick, e % 10 == 0);
            else n_pass++;
            n_chk++;
            if (phase !== DIV_W'(e % 10)) $display("FAIL basic_phase e=%0d got %0d want %0d", e, phase, e % 10);
            else n_pass++;
        end
    endtask

    task automatic test_div_reload();
        bit exp;
        do_reset();
        drive_edge(1, 0, 0, 0, 0);
        for (int e = 1; e <= 27; e++) begin
            drive_edge(0, 0, e == 14, 3, 0);
            exp = (e == 10 || e == 20 || e == 23 || e == 26);
            n_chk++;
            if (tick !== exp) $display("FAIL reload_tick e=%0d got %b want %b", e, tick, exp);
            else n_pass++;
        end
    endtask

    task automatic test_div_zero();
        do_reset();
        drive_edge(0, 0, 1, 0, 0);
        drive_edge(1, 0, 0, 0, 0);
        n_chk++; if (tick !== 1'b0) $display("FAIL divzero_tick0 got %b want 0", tick); else n_pass++;
        for (int e = 1; e <= 8; e++) begin
            drive_edge(0, 0, 0, 0, 0);
            n_chk++;
            if (tick !== 1'b1 || phase !== '0)
                $display("FAIL divzero e=%0d got tick=%b phase=%0d want tick=1 phase=0", e, tick, phase);
            else n_pass++;
        end
    endtask

    task automatic test_start_stop();
        do_reset();
        drive_edge(1, 0, 0, 0, 0);
        for (int e = 1; e <= 4; e++) drive_edge(0, 0, 0, 0, 0);
        drive_edge(1, 1, 0, 0, 0);
        n_chk++;
        if (running !== 1'b0 || phase !== '0 || tick !== 1'b0)
            $display("FAIL startstop_edge5 got run=%b phase=%0d tick=%b want 0/0/0", running, phase, tick);
        else n_pass++;
        for (int e = 6; e <= 14; e++) begin
            drive_edge(0, 0, 0, 0, 0);
            n_chk++;
            if (tick !== 1'b0 || running !== 1'b0)
                $display("FAIL startstop_idle e=%0d got tick=%b run=%b want 0/0", e, tick, running);
            else n_pass++;
        end
    endtask

    task automatic test_resync_and_reset();
        int ep;
        do_reset();
        drive_edge(1, 0, 0, 0, 0);
        for (int e = 1; e <= 17; e++) begin
            drive_edge(e == 7, 0, e == 12, 3, 0);
            ep = (e < 7) ? e : (e - 7) % 10;
            n_chk++;
            if (tick !== (e == 17) || phase !== DIV_W'(ep))
                $display("FAIL resync e=%0d got tick=%b phase=%0d want tick=%b phase=%0d",
                         e, tick, phase, e == 17, ep);
            else n_pass++;
        end
        // tick is high here; reset must clear it without waiting for an edge
        #2 reset_n = 0;
        model_reset();
        #1;
        n_chk++;
        if (tick !== 1'b0 || running !== 1'b0 || phase !== '0)
            $display("FAIL async_reset got tick=%b run=%b phase=%0d want 0/0/0", tick, running, phase);
        else n_pass++;
        @(posedge clk); #1 reset_n = 1;
        drive_edge(1, 0, 0, 0, 0);
        for (int e = 1; e <= 11; e++) begin
            drive_edge(0, 0, 0, 0, 0);
            n_chk++;
            if (tick !== (e == 10)) $display("FAIL reset_div e=%0d got %b want %b", e, tick, e == 10);
            else n_pass++;
        end
    endtask

`ifdef TICK_GEN_ONESHOT_EN
    task automatic test_oneshot();
        do_reset();
        drive_edge(0, 0, 1, 4, 0);
        drive_edge(1, 0, 0, 0, 1);
        for (int e = 1; e <= 24; e++) begin
            drive_edge(0, 0, 0, 0, 0);
            n_chk++;
            if (tick !== (e == 4) || running !== (e < 4))
                $display("FAIL oneshot e=%0d got tick=%b run=%b want tick=%b run=%b",
                         e, tick, running, e == 4, e < 4);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        bit s, p, ld, os;
        int din;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            s   = ($urandom_range(99) < 3);
            p   = ($urandom_range(99) < 2);
            ld  = ($urandom_range(99) < 5);
            din = $urandom_range(12);
            os  = OS_EN && ($urandom_range(3) == 0);
            drive_edge(s, p, ld, din, os);
            n_chk++;
            if (tick !== m_tick || running !== m_run || phase !== DIV_W'(m_phase()))
                $display("FAIL random i=%0d got tick=%b run=%b phase=%0d want tick=%b run=%b phase=%0d",
                         i, tick, running, phase, m_tick, m_run, m_phase());
            else n_pass++;
        end
    endtask

    initial begin
        m_n = 0;
        model_reset();
        test_reset();
        test_basic();
        test_div_reload();
        test_div_zero();
        test_start_stop();
        test_resync_and_reset();
`ifdef TICK_GEN_ONESHOT_EN
        test_oneshot();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
